// File: rtl/clock_divider_scale_sequencer.sv
// Drives the clock_divider scale input, changing it only on divided-clock period
// boundaries, from either host requests or an autonomous triangle sweep.
module clock_divider_scale_sequencer #(
   parameter logic [7:0] RESET_SCALE = 8'd1
) (
   input  logic       clk_in,
   input  logic       nrst,
   input  logic       req_valid,
   input  logic [7:0] req_scale,
   output logic       req_ready,
   input  logic       sweep_en,
   input  logic [7:0] sweep_lo,
   input  logic [7:0] sweep_hi,
   input  logic [7:0] sweep_hold,
   input  logic       div_clk,
   output logic [7:0] scale_out,
   output logic       applied,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, PENDING, SWEEP} state_t;

   state_t     state, state_nxt;
   logic       div_q;
   logic [7:0] pending, pending_nxt;
   logic [7:0] scale_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic       dir_up, dir_nxt;
   logic       arm, arm_nxt;
   logic       applied_nxt;
   logic       boundary;
   logic       sweep_ok;

   // A stopped divider (scale 0) never produces an edge, so every cycle counts as a boundary.
   assign boundary  = (div_clk & ~div_q) | (scale_out == 8'd0);
   assign sweep_ok  = sweep_en & (sweep_lo <= sweep_hi);
   assign req_ready = (state == IDLE) & ~sweep_ok;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         div_q     <= 1'b0;
         pending   <= 8'd0;
         scale_out <= RESET_SCALE;
         hold_cnt  <= 8'd0;
         dir_up    <= 1'b1;
         arm       <= 1'b0;
         applied   <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_q     <= div_clk;
         pending   <= pending_nxt;
         scale_out <= scale_nxt;
         hold_cnt  <= hold_nxt;
         dir_up    <= dir_nxt;
         arm       <= arm_nxt;
         applied   <= applied_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      scale_nxt   = scale_out;
      hold_nxt    = hold_cnt;
      dir_nxt     = dir_up;
      arm_nxt     = arm;
      applied_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (sweep_ok) begin
               state_nxt = SWEEP;
               arm_nxt   = 1'b1;
            end else if (req_valid) begin
               pending_nxt = req_scale;
               state_nxt   = PENDING;
            end
         end
         PENDING: begin
            if (boundary) begin
               scale_nxt   = pending;
               applied_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         SWEEP: begin
            if (!sweep_ok) begin
               state_nxt = IDLE;
            end else if (boundary) begin
               if (arm) begin
                  scale_nxt   = sweep_lo;
                  dir_nxt     = 1'b1;
                  hold_nxt    = 8'd0;
                  arm_nxt     = 1'b0;
                  applied_nxt = 1'b1;
               end else if (hold_cnt != sweep_hold) begin
                  hold_nxt = hold_cnt + 8'd1;
               end else begin
                  hold_nxt = 8'd0;
                  // Bounds may have moved under us; restart from the bottom if so.
                  if ((scale_out < sweep_lo) || (scale_out > sweep_hi)) begin
                     scale_nxt   = sweep_lo;
                     dir_nxt     = 1'b1;
                     applied_nxt = 1'b1;
                  end else if (sweep_lo != sweep_hi) begin
                     applied_nxt = 1'b1;
                     if (dir_up) begin
                        if (scale_out < sweep_hi) begin
                           scale_nxt = scale_out + 8'd1;
                        end else begin
                           dir_nxt   = 1'b0;
                           scale_nxt = scale_out - 8'd1;
                        end
                     end else begin
                        if (scale_out > sweep_lo) begin
                           scale_nxt = scale_out - 8'd1;
                        end else begin
                           dir_nxt   = 1'b1;
                           scale_nxt = scale_out + 8'd1;
                        end
                     end
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
